// File: rtl/mul_arb_pkg.sv
// Shared types and slave register map for the multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_RD,
    ST_CAP
  } state_t;

  // The slave returns the product when read at the first operand address.
  localparam logic [1:0] ADDR_DATA1 = 2'b00;
  localparam logic [1:0] ADDR_DATA2 = 2'b01;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  logic [1:0] w_eff;

  always_comb begin
    w_eff = req & ~mask;
    valid = |w_eff;
    if (&w_eff) grant = ~last;
    else        grant = w_eff[1];
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one memory-mapped multiplier slave between two requesters:
// write op_a, write op_b, read product, capture, then pulse done.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic signed [DATA_W-1:0] op_a0,
  input  logic signed [DATA_W-1:0] op_b0,
  input  logic signed [DATA_W-1:0] op_a1,
  input  logic signed [DATA_W-1:0] op_b1,
  output logic                     done0,
  output logic                     done1,
  output logic signed [DATA_W-1:0] result0,
  output logic signed [DATA_W-1:0] result1,
  output logic                     busy,
  output logic [1:0]               mul_address,
  output logic [DATA_W-1:0]        mul_writedata,
  output logic                     mul_write,
  output logic                     mul_read,
  output logic                     mul_chipselect,
  input  logic [DATA_W-1:0]        mul_readdata
);

  state_t                     r_state;
  logic                       r_gnt;
  logic                       r_last;
  logic signed [DATA_W-1:0]   r_op_b;
  logic                       r_done0, r_done1;
  logic signed [DATA_W-1:0]   r_result0, r_result1;
  logic [1:0]                 r_addr;
  logic [DATA_W-1:0]          r_wdata;
  logic                       r_write, r_read, r_cs;

  logic                       w_grant;
  logic                       w_valid;

  // A requester still seeing its done pulse has not yet had a chance to drop req.
  rr_arb2 u_rr_arb2 (
    .req   ({req1, req0}),
    .mask  ({r_done1, r_done0}),
    .last  (r_last),
    .grant (w_grant),
    .valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_op_b    <= '0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_result0 <= '0;
      r_result1 <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_cs      <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_cs    <= 1'b0;
      // Bus strobes are registered alongside the state they belong to.
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_gnt   <= w_grant;
            r_last  <= w_grant;
            r_op_b  <= w_grant ? op_b1 : op_b0;
            r_cs    <= 1'b1;
            r_write <= 1'b1;
            r_addr  <= ADDR_DATA1;
            r_wdata <= w_grant ? op_a1 : op_a0;
            r_state <= ST_WR_A;
          end
        end
        ST_WR_A: begin
          r_cs    <= 1'b1;
          r_write <= 1'b1;
          r_addr  <= ADDR_DATA2;
          r_wdata <= r_op_b;
          r_state <= ST_WR_B;
        end
        ST_WR_B: begin
          r_cs    <= 1'b1;
          r_read  <= 1'b1;
          r_addr  <= ADDR_DATA1;
          r_state <= ST_RD;
        end
        ST_RD: begin
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          if (r_gnt) begin
            r_result1 <= mul_readdata;
            r_done1   <= 1'b1;
          end else begin
            r_result0 <= mul_readdata;
            r_done0   <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done0          = r_done0;
  assign done1          = r_done1;
  assign result0        = r_result0;
  assign result1        = r_result1;
  assign busy           = (r_state != ST_IDLE);
  assign mul_address    = r_addr;
  assign mul_writedata  = r_wdata;
  assign mul_write      = r_write;
  assign mul_read       = r_read;
  assign mul_chipselect = r_cs;

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (matches the multiplier slave word).
REQ-002 SHALL have ports: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have ports: reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-004 SHALL have ports: req0 / req1  input  1  requester level request, held until matching done.
REQ-005 SHALL have ports: op_a0, op_b0 / op_a1, op_b1  input  DATA_W  signed operands per requester.
REQ-006 SHALL have ports: done0 / done1  output  1  one-cycle completion pulse per requester.
REQ-007 SHALL have ports: result0 / result1  output  DATA_W  signed product per requester, held until that requester's next done.
REQ-008 SHALL have ports: busy  output  1  high whenever the FSM is not IDLE.
REQ-009 SHALL have ports: mul_address  output  2, mul_writedata  output  DATA_W, mul_write, mul_read, mul_chipselect  output  1 each, mul_readdata  input  DATA_W: master side to the multiplier slave.

Function
REQ-010 SHALL implement FSM IDLE -> WR_A -> WR_B -> RD -> CAP -> IDLE, one cycle per state, no stalls.
REQ-011 IDLE: if any unmasked request, SHALL grant one, latch its op_a/op_b and the grant index, and go to WR_A; otherwise stay.
REQ-012 Arbitration SHALL be round-robin: on simultaneous req0/req1, the requester not served last wins; a lone request is granted regardless of history.
REQ-013 WR_A SHALL drive chipselect=1, write=1, address=2'b00, writedata=latched op_a.
REQ-014 WR_B SHALL drive chipselect=1, write=1, address=2'b01, writedata=latched op_b.
REQ-015 RD SHALL drive chipselect=1, read=1, address=2'b00; write=0.
REQ-016 CAP SHALL drive all bus strobes low and register mul_readdata (valid this cycle, one cycle after read) into result of the granted requester.
REQ-017 done of the granted requester SHALL be high exactly in the cycle after CAP (FSM back in IDLE); the other done stays low.
REQ-018 In IDLE, a requester whose done is high this cycle SHALL be masked from arbitration.
REQ-019 Latency: request present at IDLE edge k -> done high in cycle k+5; back-to-back service SHALL be one transaction per 5 cycles.
REQ-020 Result SHALL be the low DATA_W bits of the signed product as returned by the slave; no saturation or overflow flag.
REQ-021 Bus outputs SHALL be Moore outputs of registered state; in IDLE all strobes are 0, address and writedata are 0.
REQ-022 Operand changes after the grant SHALL NOT affect the in-flight transaction.
REQ-023 A request dropped after grant SHALL NOT abort the transaction; done still pulses.

Reset
REQ-024 While reset=0 at a clk edge, SHALL enter IDLE, clear done0/done1, result0/result1, busy, all mul_* outputs to 0, and set round-robin history so req0 wins the first tie.
REQ-025 Reset mid-transaction SHALL abandon it with no done pulse and no result update; the slave's operand registers are don't-care afterwards since every transaction rewrites both.

Structure
REQ-026 Shared package mul_arb_pkg SHALL hold the FSM state enum and the slave address constants (ADDR_DATA1=2'b00, ADDR_DATA2=2'b01).
REQ-027 Round-robin grant logic SHALL be a sub-module rr_arb2 (req[1:0], mask, last -> grant, valid); FSM and datapath stay in mul_arbiter.

Verification
REQ-028 Bench SHALL instantiate a behavioral multiplier slave with registered readdata (one-cycle read latency) and cover:
REQ-029 req0 with op_a0=3, op_b0=4 -> bus writes 00:3, 01:4, then read; done0 in cycle k+5, result0=12; done1 never asserts.
REQ-030 req1 with op_a1=-5, op_b1=7 -> result1=0xFFFFFFDD, done1 only; result0 unchanged.
REQ-031 req0 and req1 asserted same cycle after reset, held until own done -> done0 at k+5, done1 at k+10; repeat -> order alternates via round-robin.
REQ-032 op_a0=0x00010000, op_b0=0x00010000 -> result0=0x00000000 (truncation); operands changed to 1 at cycle k+1 -> no effect.
REQ-033 reset=0 asserted during WR_B -> next cycle all outputs 0, busy=0, no done; subsequent req0 (2x6) completes with result0=12.
